// File: rtl/instr_fetch.sv
// instr_fetch
//   Instruction fetch stage. Holds the program counter, issues one word
//   request at a time to instruction memory, registers the returned word and
//   presents it to decode until decode accepts it. Decode may redirect the PC
//   on acceptance (taken branch/jump); a flush redirects from any state.
//
// Ports
//   clk, reset       : clock, asynchronous active-high reset
//   imem_req         : one-cycle request pulse (only in ISSUE)
//   imem_addr        : request word address, always equal to pc
//   imem_rvalid      : memory response valid
//   imem_rdata       : memory response word
//   instr            : held instruction (NOP_INSTR when not valid)
//   instr_valid      : instr is valid for decode
//   instr_ready      : decode accepts instr this cycle
//   pcsrc, pctarget  : redirect request, sampled only on handshake
//   flush, flush_pc  : trap redirect, highest priority
//   pc, pcplus4      : current/pending instruction address and pc + 4
//   instr_misalign   : one-cycle pulse when a loaded target was misaligned
//   retire_count     : wrapping count of handshakes

module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pcsrc,
  input  logic [31:0] pctarget,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        instr_misalign,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HOLD,
    DROP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic        valid_nxt;
  logic        misalign_nxt;
  logic [31:0] rc_nxt;

  assign pcplus4   = pc + 32'd4;
  assign imem_addr = pc;

  // A flush in ISSUE suppresses that cycle's request so that the redirected
  // PC is the one actually fetched and no orphan response is left in flight.
  assign imem_req = (state == ISSUE) && !reset && !flush;

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ISSUE;
      pc             <= RESET_PC;
      instr          <= NOP_INSTR;
      instr_valid    <= 1'b0;
      instr_misalign <= 1'b0;
      retire_count   <= 32'd0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      instr          <= instr_nxt;
      instr_valid    <= valid_nxt;
      instr_misalign <= misalign_nxt;
      retire_count   <= rc_nxt;
    end
  end

  // Next-state and next-value logic. Flush wins over everything; a flush
  // while a response is still owed moves to DROP so that response is eaten.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = instr;
    valid_nxt    = instr_valid;
    misalign_nxt = 1'b0;
    rc_nxt       = retire_count;

    if (flush) begin
      pc_nxt       = {flush_pc[31:2], 2'b00};
      misalign_nxt = |flush_pc[1:0];
      valid_nxt    = 1'b0;
      instr_nxt    = NOP_INSTR;
      case (state)
        WAIT:    state_nxt = imem_rvalid ? ISSUE : DROP;
        DROP:    state_nxt = imem_rvalid ? ISSUE : DROP;
        default: state_nxt = ISSUE;
      endcase
    end else begin
      case (state)
        ISSUE: begin
          state_nxt = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr_nxt = imem_rdata;
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            if (pcsrc) begin
              pc_nxt       = {pctarget[31:2], 2'b00};
              misalign_nxt = |pctarget[1:0];
            end else begin
              pc_nxt = pcplus4;
            end
            valid_nxt = 1'b0;
            instr_nxt = NOP_INSTR;
            rc_nxt    = retire_count + 32'd1;
            state_nxt = ISSUE;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            state_nxt = ISSUE;
          end
        end
        default: begin
          state_nxt = ISSUE;
        end
      endcase
    end
  end

endmodule
